// File: rtl/flow_dispatch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | flow_dispatch_pkg                                                    |
// | FSM encodings and descriptor layout shared by the flow dispatcher.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package flow_dispatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_ACK = 2'd2
  } state_t;

  // A descriptor is {SA, SB, SC, IP} with SA in the MSBs; FLD_* give the
  // segment slot of each field counted from the LSB end.
  localparam int DESC_FIELDS = 4;
  localparam int FLD_SA      = 3;
  localparam int FLD_SB      = 2;
  localparam int FLD_SC      = 1;
  localparam int FLD_IP      = 0;

endpackage
`default_nettype wire

// File: rtl/flow_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | flow_fifo                                                            |
// | DEPTH x WIDTH synchronous FIFO with push, pop, full, empty and count.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module flow_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Ready depends only on full, so a pop in the same cycle never frees a slot early.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule
`default_nettype wire

// File: rtl/flow_dispatch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | flow_dispatch                                                        |
// | Queues flow descriptors and dispatches them round-robin to idle      |
// | slave cores. Optional acknowledge watchdog: FLOW_DISPATCH_WDOG_EN.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module flow_dispatch
  import flow_dispatch_pkg::*;
#(
  parameter int N_SLAVE  = 4,
  parameter int SEG_W    = 16,
  parameter int DEPTH    = 4,
  parameter int WDOG_CYC = 15
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         REQ_VALID,
  input  logic [SEG_W-1:0]             REQ_SA,
  input  logic [SEG_W-1:0]             REQ_SB,
  input  logic [SEG_W-1:0]             REQ_SC,
  input  logic [SEG_W-1:0]             REQ_IP,
  output logic                         REQ_READY,
  input  logic [N_SLAVE-1:0]           INT,
  output logic [N_SLAVE-1:0]           START_NEW_FLOW,
  output logic [SEG_W-1:0]             SA_M,
  output logic [SEG_W-1:0]             SB_M,
  output logic [SEG_W-1:0]             SC_M,
  output logic [SEG_W-1:0]             IP_M,
  output logic [N_SLAVE-1:0]           EN,
  output logic [$clog2(DEPTH+1)-1:0]   QUEUE_CNT,
  output logic                         BUSY,
  output logic                         ERR,
  output logic [$clog2(N_SLAVE)-1:0]   ERR_ID
);

  localparam int IW = $clog2(N_SLAVE);
  localparam int DW = DESC_FIELDS * SEG_W;

  state_t              state;
  logic [IW-1:0]       ptr;
  logic [IW-1:0]       target;
  logic [DW-1:0]       req_desc;
  logic [DW-1:0]       head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                grant_found;
  logic [IW-1:0]       grant;
  logic                dispatch;
  logic                timeout;
  logic [N_SLAVE-1:0]  en_next;

  assign req_desc = {REQ_SA, REQ_SB, REQ_SC, REQ_IP};

  flow_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DW)
  ) u_fifo (
    .CLK       (CLK),
    .RESET     (RESET),
    .push      (REQ_VALID),
    .push_data (req_desc),
    .pop       (dispatch),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (QUEUE_CNT)
  );

  assign REQ_READY = !fifo_full;
  assign BUSY      = !fifo_empty || (state != ST_IDLE);

  // First idle slave at or after the pointer, wrapping past N_SLAVE-1.
  always_comb begin
    grant_found = 1'b0;
    grant       = '0;
    for (int k = 0; k < N_SLAVE; k++) begin
      if (!grant_found && INT[(int'(ptr) + k) % N_SLAVE]) begin
        grant_found = 1'b1;
        grant       = IW'((int'(ptr) + k) % N_SLAVE);
      end
    end
  end

  assign dispatch = (state == ST_IDLE) && !fifo_empty && grant_found;

  // A core keeps its clock while busy or while it is the outstanding target.
  always_comb begin
    en_next = '0;
    for (int i = 0; i < N_SLAVE; i++) begin
      en_next[i] = EN[i] && (!INT[i] || ((state != ST_IDLE) && (target == IW'(i))));
      if (dispatch && (grant == IW'(i))) begin
        en_next[i] = 1'b1;
      end
      if (timeout && (target == IW'(i))) begin
        en_next[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state          <= ST_IDLE;
      ptr            <= '0;
      target         <= '0;
      START_NEW_FLOW <= '0;
      EN             <= '0;
      SA_M           <= '0;
      SB_M           <= '0;
      SC_M           <= '0;
      IP_M           <= '0;
    end else begin
      EN <= en_next;
      case (state)
        ST_IDLE: begin
          if (dispatch) begin
            state          <= ST_ISSUE;
            target         <= grant;
            START_NEW_FLOW <= {{(N_SLAVE-1){1'b0}}, 1'b1} << grant;
            SA_M           <= head[FLD_SA*SEG_W +: SEG_W];
            SB_M           <= head[FLD_SB*SEG_W +: SEG_W];
            SC_M           <= head[FLD_SC*SEG_W +: SEG_W];
            IP_M           <= head[FLD_IP*SEG_W +: SEG_W];
            ptr            <= (grant == IW'(N_SLAVE-1)) ? '0 : grant + IW'(1);
          end
        end
        ST_ISSUE: begin
          START_NEW_FLOW <= '0;
          state          <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (!INT[target] || timeout) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state          <= ST_IDLE;
          START_NEW_FLOW <= '0;
        end
      endcase
    end
  end

`ifdef FLOW_DISPATCH_WDOG_EN
  localparam int WCW = $clog2(WDOG_CYC+1);

  logic [WCW-1:0] wdog_cnt;
  logic           err_q;
  logic [IW-1:0]  err_id_q;

  // An acknowledge sampled on the expiry edge wins over the timeout.
  assign timeout = (state == ST_WAIT_ACK) && INT[target] &&
                   (wdog_cnt == WCW'(WDOG_CYC-1));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wdog_cnt <= '0;
      err_q    <= 1'b0;
      err_id_q <= '0;
    end else begin
      if (dispatch) begin
        wdog_cnt <= '0;
      end else if (state == ST_WAIT_ACK) begin
        wdog_cnt <= wdog_cnt + WCW'(1);
      end
      if (timeout) begin
        err_q    <= 1'b1;
        err_id_q <= target;
      end
    end
  end

  assign ERR    = err_q;
  assign ERR_ID = err_id_q;
`else
  logic unused_wdog_cyc;

  assign unused_wdog_cyc = (WDOG_CYC != 0);
  assign timeout         = 1'b0;
  assign ERR             = 1'b0;
  assign ERR_ID          = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_flow_dispatch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_flow_dispatch                                                     |
// | Randomised scoreboard bench with idle-flag slave responders.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_flow_dispatch;

  localparam int N     = 4;
  localparam int SW    = 16;
  localparam int DEPTH = 4;
  localparam int WDOG  = 15;
`ifdef FLOW_DISPATCH_WDOG_EN
  localparam bit WDOG_ON = 1'b1;
`else
  localparam bit WDOG_ON = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          REQ_VALID = 1'b0;
  logic [SW-1:0] REQ_SA = '0, REQ_SB = '0, REQ_SC = '0, REQ_IP = '0;
  logic          REQ_READY;
  logic [N-1:0]  INT = '1;
  logic [N-1:0]  START_NEW_FLOW;
  logic [SW-1:0] SA_M, SB_M, SC_M, IP_M;
  logic [N-1:0]  EN;
  logic [2:0]    QUEUE_CNT;
  logic          BUSY;
  logic          ERR;
  logic [1:0]    ERR_ID;

  flow_dispatch #(
    .N_SLAVE (N), .SEG_W (SW), .DEPTH (DEPTH), .WDOG_CYC (WDOG)
  ) dut (
    .CLK (CLK), .RESET (RESET),
    .REQ_VALID (REQ_VALID), .REQ_SA (REQ_SA), .REQ_SB (REQ_SB),
    .REQ_SC (REQ_SC), .REQ_IP (REQ_IP), .REQ_READY (REQ_READY),
    .INT (INT), .START_NEW_FLOW (START_NEW_FLOW),
    .SA_M (SA_M), .SB_M (SB_M), .SC_M (SC_M), .IP_M (IP_M),
    .EN (EN), .QUEUE_CNT (QUEUE_CNT), .BUSY (BUSY),
    .ERR (ERR), .ERR_ID (ERR_ID)
  );

  always #5 CLK = ~CLK;

  // Slave responders: drop INT the cycle after sampling their pulse, stay busy a while.
  logic [N-1:0] int_auto = '1;
  logic [N-1:0] mask = '1;
  logic [N-1:0] ack_en = '1;
  logic [N-1:0] snap;
  int           busy_cnt [N];
  int           busy_max = 3;

  always begin
    @(negedge CLK);
    snap = START_NEW_FLOW;
    @(posedge CLK);
    #1;
    if (!RESET) begin
      int_auto = '1;
      for (int i = 0; i < N; i++) busy_cnt[i] = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (snap[i] && ack_en[i]) begin
          int_auto[i] = 1'b0;
          busy_cnt[i] = $urandom_range(1, busy_max);
        end else if (!int_auto[i]) begin
          if (busy_cnt[i] == 0) int_auto[i] = 1'b1;
          else busy_cnt[i]--;
        end
      end
    end
    INT = int_auto & mask;
  end

  // Scoreboard and reference model of the dispatcher's observable behaviour.
  int            total = 0;
  int            bad = 0;
  logic [63:0]   sb [$];
  int            m_cnt = 0, m_ptr = 0, m_tgt = 0, m_age = 0, m_errid = 0;
  bit            m_out = 0, m_err = 0;
  logic [N-1:0]  en_m = '0;
  logic [63:0]   m_last = '0;
  logic [N-1:0]  p_int = '1;
  bit            p_valid = 0;
  logic [63:0]   p_desc = '0;
  bit            done = 0;
  bit            stim_to = 0;
  int            drain_req = 0;
  int            drain_seen = 0;

  int            cnt_before, g;
  bit            exp_disp, ack_rel, tmo;
  logic [N-1:0]  exp_pulse;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (!RESET) begin
      sb.delete();
      m_cnt = 0; m_ptr = 0; m_tgt = 0; m_age = 0; m_out = 0;
      m_err = 0; m_errid = 0; en_m = '0; m_last = '0;
      chk("rst_pulse", START_NEW_FLOW, 0);
      chk("rst_en", EN, 0);
      chk("rst_ready", REQ_READY, 1);
      chk("rst_cnt", QUEUE_CNT, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_err", ERR, 0);
      chk("rst_err_id", ERR_ID, 0);
      chk("rst_desc", {SA_M, SB_M, SC_M, IP_M}, 0);
    end else begin
      cnt_before = m_cnt;
      exp_disp = !m_out && (m_cnt > 0) && (p_int != '0);
      g = 0;
      for (int k = N-1; k >= 0; k--) if (p_int[(m_ptr + k) % N]) g = (m_ptr + k) % N;

      ack_rel = m_out && (m_age >= 1) && !p_int[m_tgt];
      tmo     = WDOG_ON && m_out && !ack_rel && (m_age == WDOG);
      for (int i = 0; i < N; i++)
        if (p_int[i] && !(m_out && m_tgt == i)) en_m[i] = 1'b0;
      if (tmo) begin
        en_m[m_tgt] = 1'b0;
        m_err = 1;
        m_errid = m_tgt;
      end
      if (ack_rel || tmo) m_out = 0;
      else if (m_out) m_age++;

      exp_pulse = '0;
      if (exp_disp) begin
        exp_pulse[g] = 1'b1;
        en_m[g] = 1'b1;
        m_tgt = g;
        m_out = 1;
        m_age = 0;
        m_ptr = (g + 1) % N;
        m_last = sb.pop_front();
        m_cnt--;
      end
      if (p_valid && cnt_before < DEPTH) begin
        sb.push_back(p_desc);
        m_cnt++;
      end

      chk("pulse", START_NEW_FLOW, exp_pulse);
      chk("desc_m", {SA_M, SB_M, SC_M, IP_M}, m_last);
      chk("en", EN, en_m);
      chk("queue_cnt", QUEUE_CNT, m_cnt);
      chk("req_ready", REQ_READY, m_cnt < DEPTH);
      chk("busy", BUSY, (m_cnt > 0) || m_out);
      chk("err", ERR, m_err);
      chk("err_id", ERR_ID, m_errid);
    end
    if (drain_req != drain_seen) begin
      chk("drained", sb.size() + int'(m_out), 0);
      drain_seen = drain_req;
    end
    p_int   = INT;
    p_valid = REQ_VALID;
    p_desc  = {REQ_SA, REQ_SB, REQ_SC, REQ_IP};
    if (done) begin
      chk("stim_timeout", stim_to, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  // Stimulus; every task returns one time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic push(input logic [63:0] d);
    {REQ_SA, REQ_SB, REQ_SC, REQ_IP} = d;
    REQ_VALID = 1'b1;
    for (int w = 0; w < 200; w++) begin
      @(negedge CLK);
      if (REQ_READY) begin
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b0;
        return;
      end
      @(posedge CLK);
      #1;
    end
    stim_to = 1;
    REQ_VALID = 1'b0;
  endtask

  task automatic do_reset();
    #2 RESET = 1'b0;
    repeat (2) @(negedge CLK);
    #1 RESET = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [63:0] rnd_desc();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    #1 RESET = 1'b0;
    repeat (3) @(negedge CLK);
    #1 RESET = 1'b1;
    @(posedge CLK);
    #1;

    push({16'h1, 16'h2, 16'h3, 16'h10});
    idle(10);

    busy_max = 12;
    for (int i = 0; i < 5; i++) push(rnd_desc());
    idle(40);
    drain_req++;

    mask = '0;
    idle(2);
    for (int i = 0; i < DEPTH; i++) push(rnd_desc());
    {REQ_SA, REQ_SB, REQ_SC, REQ_IP} = 64'h0bad_cafe_1234_5678;
    REQ_VALID = 1'b1;
    idle(6);
    mask = '1;
    push(64'h0bad_cafe_1234_5678);
    idle(60);
    drain_req++;

    busy_max = 2;
    do_reset();
    push(rnd_desc());
    idle(12);
    mask = 4'b1001;
    idle(2);
    push(rnd_desc());
    idle(12);
    mask = '1;
    idle(2);
    push(rnd_desc());
    idle(12);

    busy_max = 6;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) mask = 4'($urandom()) | (4'b1 << $urandom_range(0, 3));
      push(rnd_desc());
      idle($urandom_range(0, 3));
    end
    mask = '1;
    idle(60);
    drain_req++;
    idle(2);

    ack_en = '0;
    for (int i = 0; i < 3; i++) push(rnd_desc());
    idle(30);
    do_reset();
    ack_en = '1;
    idle(15);
    done = 1;
    idle(5);
  end

endmodule
`default_nettype wire
